alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU that extends the combinational 32-bit ALU.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_core.sv | 93 +++++++++
 rtl/alu_mc.sv | 175 +++++++++++++++++
 tb/tb_alu_mc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/compare-mode encodings, FSM state type and a constant log2 helper
// for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SET = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  localparam logic [2:0] SET_SLT = 3'b000;
  localparam logic [2:0] SET_SGT = 3'b001;
  localparam logic [2:0] SET_SLE = 3'b010;
  localparam logic [2:0] SET_SGE = 3'b011;
  localparam logic [2:0] SET_SEQ = 3'b110;
  localparam logic [2:0] SET_SNE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath: logic ops, add/sub with carry and overflow,
// signed SET compares and opcode legality. Shift and MUL results come from alu_mc.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  input  logic [2:0]       bonus_control,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             illegal,
  output logic             is_mul
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] nor_v;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;
  logic             eq;
  logic             set_bit;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_v[gi] = a[gi] & b[gi];
      assign or_v[gi]  = a[gi] | b[gi];
      assign nor_v[gi] = ~(a[gi] | b[gi]);
    end
  endgenerate

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (a[MSB] == b[MSB]) & (add_full[MSB] != a[MSB]);
  // For SUB the second operand is ~b, so "same sign" means a and b differ.
  assign sub_ovf  = (a[MSB] != b[MSB]) & (sub_full[MSB] != a[MSB]);
  assign lt       = sub_full[MSB] ^ sub_ovf;
  assign eq       = (sub_full[MSB:0] == '0);

  always_comb begin
    set_bit = lt;
    case (bonus_control)
      SET_SLT: set_bit = lt;
      SET_SGT: set_bit = ~lt & ~eq;
      SET_SLE: set_bit = lt | eq;
      SET_SGE: set_bit = ~lt;
      SET_SEQ: set_bit = eq;
      SET_SNE: set_bit = ~eq;
      default: set_bit = lt;
    endcase
  end

  always_comb begin
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    is_mul   = 1'b0;
    case (alu_control)
      OP_AND: result = and_v;
      OP_OR:  result = or_v;
      OP_NOR: result = nor_v;
      OP_ADD: begin
        result   = add_full[MSB:0];
        cout     = add_full[WIDTH];
        overflow = add_ovf;
      end
      OP_SUB: begin
        result   = sub_full[MSB:0];
        cout     = sub_full[WIDTH];
        overflow = sub_ovf;
      end
      OP_SET: result = {{(WIDTH-1){1'b0}}, set_bit};
      OP_SLL, OP_SRL, OP_SRA: result = '0;
      OP_MUL: begin
        is_mul  = MUL_EN;
        illegal = ~MUL_EN;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: handshaked front end, bit-serial shifts and shift-add multiply,
// registered result and flags held until the consumer takes them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  input  logic [2:0]       bonus_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             illegal
);

  localparam int MSB   = WIDTH - 1;
  localparam int SH_W  = clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] core_result;
  logic             core_cout;
  logic             core_overflow;
  logic             core_illegal;
  logic             core_is_mul;

  logic             accept;
  logic             is_shift;
  logic [SH_W-1:0]  shift_amt;
  logic [WIDTH-1:0] shift_step;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] fin_val;

  alu_core #(
    .WIDTH  (WIDTH),
    .MUL_EN (MUL_EN)
  ) u_core (
    .a             (src1),
    .b             (src2),
    .alu_control   (ALU_control),
    .bonus_control (bonus_control),
    .result        (core_result),
    .cout          (core_cout),
    .overflow      (core_overflow),
    .illegal       (core_illegal),
    .is_mul        (core_is_mul)
  );

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign is_shift  = (ALU_control == OP_SLL) | (ALU_control == OP_SRL) | (ALU_control == OP_SRA);
  assign shift_amt = src2[SH_W-1:0];

  // MUL shifts its multiplicand left each step, so it shares the SLL path.
  always_comb begin
    shift_step = a_q << 1;
    case (op_q)
      OP_SRL:  shift_step = a_q >> 1;
      OP_SRA:  shift_step = {a_q[MSB], a_q[MSB:1]};
      default: shift_step = a_q << 1;
    endcase
  end

  assign acc_step = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    fin_val    = '0;

    if (state_q == ST_BUSY) begin
      a_d   = shift_step;
      b_d   = b_q >> 1;
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        fin_val    = (op_q == OP_MUL) ? acc_step : shift_step;
        state_d    = ST_DONE;
        result_d   = fin_val;
        zero_d     = (fin_val == '0);
        cout_d     = 1'b0;
        overflow_d = 1'b0;
        illegal_d  = 1'b0;
      end
    end else if (accept) begin
      op_d  = ALU_control;
      a_d   = src1;
      b_d   = src2;
      acc_d = '0;
      if (is_shift && (shift_amt != '0)) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(shift_amt);
      end else if (core_is_mul) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(WIDTH);
      end else begin
        fin_val    = is_shift ? src1 : core_result;
        state_d    = ST_DONE;
        result_d   = fin_val;
        zero_d     = (fin_val == '0);
        cout_d     = core_cout;
        overflow_d = core_overflow;
        illegal_d  = core_illegal;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: vector table streamed through a scoreboard (result, flags and
// latency checked per transaction), plus back-pressure and mid-operation reset sequences.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic [2:0]  bonus_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;
  logic        illegal;

  alu_mc #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .src1          (src1),
    .src2          (src2),
    .ALU_control   (ALU_control),
    .bonus_control (bonus_control),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero          (zero),
    .cout          (cout),
    .overflow      (overflow),
    .illegal       (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        il;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic        il;
    int          lat;
    int          acc_cyc;
    int          id;
  } exp_t;

  localparam int NV = 29;

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t cur_exp;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   head_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [3:0] op, input logic [2:0] mode,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic z, input logic c,
                              input logic v, input logic il, input int lat);
    vec_t t;
    t.op = op; t.mode = mode; t.a = a; t.b = b; t.res = res;
    t.z = z; t.c = c; t.v = v; t.il = il; t.lat = lat;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", name, got, exp);
    end else begin
      $display("check %s ok (%h)", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops and compares on every output handshake, pushes on every accept.
  task automatic monitor_loop();
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        head_cyc = -1;
      end else begin
        if (out_valid && head_cyc < 0) head_cyc = cyc;
        if (out_valid && out_ready) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got result=%h required=no output", result);
          end else begin
            e   = sb_q.pop_front();
            lat = head_cyc - e.acc_cyc;
            if (result !== e.res || zero !== e.z || cout !== e.c || overflow !== e.v ||
                illegal !== e.il || lat != e.lat) begin
              bad++;
              $display("FAIL txn%0d: got res=%h z=%b c=%b v=%b il=%b lat=%0d required res=%h z=%b c=%b v=%b il=%b lat=%0d",
                       e.id, result, zero, cout, overflow, illegal, lat,
                       e.res, e.z, e.c, e.v, e.il, e.lat);
            end else begin
              $display("txn%0d res=%h z=%b c=%b v=%b il=%b lat=%0d ok",
                       e.id, result, zero, cout, overflow, illegal, lat);
            end
          end
          head_cyc = -1;
        end
        if (in_valid && in_ready) begin
          e         = cur_exp;
          e.acc_cyc = cyc;
          sb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send(input vec_t v, input int id);
    int n;
    cur_exp.res = v.res; cur_exp.z = v.z; cur_exp.c = v.c; cur_exp.v = v.v;
    cur_exp.il = v.il; cur_exp.lat = v.lat; cur_exp.acc_cyc = 0; cur_exp.id = id;
    src1 = v.a; src2 = v.b; ALU_control = v.op; bonus_control = v.mode;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout txn%0d: got in_ready=0 required in_ready=1", id);
      in_valid = 1'b0;
      return;
    end
    step();
    // Scramble inputs so a design that re-reads them after accept is caught.
    in_valid      = 1'b0;
    src1          = $urandom;
    src2          = $urandom;
    ALU_control   = 4'($urandom);
    bonus_control = 3'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d required pending=0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0]  = mk(4'b0010, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 1);
    vecs[1]  = mk(4'b0110, 3'b000, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0, 0, 1);
    vecs[2]  = mk(4'b0110, 3'b000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    vecs[3]  = mk(4'b0111, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[4]  = mk(4'b0111, 3'b001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 1);
    vecs[5]  = mk(4'b0111, 3'b011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 0, 1);
    vecs[6]  = mk(4'b0111, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[7]  = mk(4'b0111, 3'b000, 32'h80000000, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[8]  = mk(4'b0111, 3'b110, 32'h00001234, 32'h00001234, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[9]  = mk(4'b0111, 3'b010, 32'h00000005, 32'h00000005, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[10] = mk(4'b0111, 3'b111, 32'h00000003, 32'h00000007, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[11] = mk(4'b0000, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0, 0, 1);
    vecs[12] = mk(4'b0001, 3'b000, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 0, 0, 0, 0, 1);
    vecs[13] = mk(4'b1100, 3'b000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
    vecs[14] = mk(4'b1100, 3'b000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1, 0, 0, 0, 1);
    vecs[15] = mk(4'b1010, 3'b000, 32'h80000000, 32'h00000004, 32'hF8000000, 0, 0, 0, 0, 5);
    vecs[16] = mk(4'b1001, 3'b000, 32'h80000000, 32'h00000004, 32'h08000000, 0, 0, 0, 0, 5);
    vecs[17] = mk(4'b1000, 3'b000, 32'h00000001, 32'h00000020, 32'h00000001, 0, 0, 0, 0, 1);
    vecs[18] = mk(4'b1000, 3'b000, 32'h00000003, 32'h0000001F, 32'h80000000, 0, 0, 0, 0, 32);
    vecs[19] = mk(4'b1011, 3'b000, 32'h00010003, 32'h00000005, 32'h0005000F, 0, 0, 0, 0, 33);
    vecs[20] = mk(4'b1011, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, 33);
    vecs[21] = mk(4'b0011, 3'b000, 32'h12345678, 32'h00000009, 32'h00000000, 1, 0, 0, 1, 1);
    vecs[22] = mk(4'b1111, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0, 1, 1);
    vecs[23] = mk(4'b0010, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, 0, 1);
    vecs[24] = mk(4'b0110, 3'b000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1, 0, 1);
    vecs[25] = mk(4'b1010, 3'b000, 32'h7FFF0000, 32'h00000008, 32'h007FFF00, 0, 0, 0, 0, 9);
    vecs[26] = mk(4'b1010, 3'b000, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 0, 0, 0, 0, 32);
    vecs[27] = mk(4'b1001, 3'b000, 32'h80000001, 32'hFFFFFFE0, 32'h80000001, 0, 0, 0, 0, 1);
    vecs[28] = mk(4'b0110, 3'b000, 32'h00000003, 32'h00000007, 32'hFFFFFFFC, 0, 0, 0, 0, 1);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src1 = '0; src2 = '0; ALU_control = '0; bonus_control = '0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_result", result, 32'h0);
    chk("reset_flags", {28'b0, zero, cout, overflow, illegal}, 32'h0);

    // Streamed back to back with out_ready high: exercises same-cycle handoff.
    for (int i = 0; i < NV; i++) send(vecs[i], i);
    wait_drain();

    // Back-pressure on a MUL result, then a queued AND taken on release.
    out_ready = 1'b0;
    send(mk(4'b1011, 3'b000, 32'h00010003, 32'h00000005, 32'h0005000F, 0, 0, 0, 0, 33), 100);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("hold_out_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("hold_result", result, 32'h0005000F);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    send(mk(4'b0000, 3'b000, 32'hFFFF0000, 32'h12345678, 32'h12340000, 0, 0, 0, 0, 1), 101);
    wait_drain();

    // Leave illegal flags held, then reset in the middle of a MUL.
    send(mk(4'b0011, 3'b000, 32'h00000001, 32'h00000001, 32'h00000000, 1, 0, 0, 1, 1), 102);
    wait_drain();
    chk("pre_reset_illegal", {31'b0, illegal}, 32'd1);
    send(mk(4'b1011, 3'b000, 32'h00000007, 32'h00000009, 32'h0000003F, 0, 0, 0, 0, 33), 103);
    repeat (9) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_result", result, 32'h0);
    chk("midreset_flags", {28'b0, zero, cout, overflow, illegal}, 32'h0);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      total++;
      if (out_valid) begin
        bad++;
        $display("FAIL midreset_ghost_output: got out_valid=1 required out_valid=0");
        break;
      end
    end

    send(mk(4'b0010, 3'b000, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, 0, 1), 104);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
